alu_wb_buffer: RTL and testbench
================================

Name: alu_wb_buffer

Overview:
- Writeback buffer directly downstream of the integer ALU.
- Captures each ALU result (64-bit result, branch-compare bit, transaction ID) in the cycle the ALU presents it.
- Holds results in a small in-order FIFO until the writeback/commit port accepts them over a valid/ready handshake.
- Decouples ALU issue from writeback-port arbitration stalls; supports a pipeline flush.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, >= 2.
- DATA_W, 64, width of ALU result.
- TRANS_ID_W, 3, width of scoreboard transaction ID.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  discard all buffered entries (pipeline flush).
- alu_valid_i  input  1  ALU result valid this cycle.
- alu_ready_o  output  1  buffer can accept an ALU result this cycle.
- alu_result_i  input  DATA_W  ALU result.
- alu_branch_res_i  input  1  ALU branch-compare outcome.
- alu_trans_id_i  input  TRANS_ID_W  transaction ID of the result.
- wb_valid_o  output  1  head entry valid.
- wb_ready_i  input  1  writeback port accepts head entry.
- wb_result_o  output  DATA_W  head entry result.
- wb_branch_res_o  output  1  head entry branch bit.
- wb_trans_id_o  output  TRANS_ID_W  head entry transaction ID.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset: synchronous on rst_i high at rising edge.
  - Read/write pointers and count go to 0.
  - wb_valid_o=0, count_o=0, alu_ready_o=1 from the cycle after reset.
  - wb_result_o, wb_branch_res_o, wb_trans_id_o read as 0 while empty; entry storage is not reset.
  - Reset takes priority over flush, push and pop. Reset mid-drain drops all entries, and nothing is presented after reset.
- Push:
  - push = alu_valid_i & alu_ready_o.
  - alu_ready_o = (count < DEPTH) & ~flush_i; combinational from registered count and flush_i only, with no dependence on wb_ready_i.
- Pop: pop = wb_valid_o & wb_ready_i.
  - wb_valid_o = (count != 0); outputs driven from the entry at the read pointer.
- Latency: an entry pushed at edge N is visible on wb_* in the cycle after edge N (1-cycle latency). There is no combinational bypass from alu_* to wb_*.
- Ordering: strict FIFO; entries leave in push order.
- Pointers: $clog2(DEPTH) bits each, wrap modulo DEPTH. Count tracks occupancy 0..DEPTH.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count == DEPTH): alu_ready_o=0 even if wb_ready_i=1 in the same cycle. A pop that cycle frees an entry, and ready rises the next cycle.
- Empty (count == 0): wb_valid_o=0. A push that cycle does not appear until the next cycle.
- alu_valid_i while alu_ready_o=0: result is not captured. The ALU must hold it; the buffer does no internal dropping.
- Flush: flush_i high at an edge sets both pointers and count to 0 and ignores push and pop that cycle. wb_valid_o=0 next cycle. alu_ready_o=0 during the flush cycle.
- wb_* stability: while wb_valid_o=1 and wb_ready_i=0, all wb_* outputs hold stable until popped or flushed.
- Widths: no arithmetic on data; fields are stored verbatim. Count arithmetic never exceeds DEPTH.

Test Plan:
- Reset then single push: rst_i=1 for 2 cycles, then push result=64'hDEAD_BEEF_0000_0001, branch=1, id=3 with wb_ready_i=1 -> next cycle wb_valid_o=1, wb_result_o=64'hDEAD_BEEF_0000_0001, wb_branch_res_o=1, wb_trans_id_o=3, count_o=1; following cycle count_o=0.
- Fill and backpressure: wb_ready_i=0, push ids 0,1,2,3 on consecutive cycles -> count_o=4, alu_ready_o=0. Fifth push with id=4 held is not captured. Raise wb_ready_i -> ids emerge 0,1,2,3,4 in order, and alu_ready_o returns 1 the cycle after the first pop.
- Wrap-around: 10 push/pop pairs with count held at 2 and results 1..10 -> output sequence exactly 1..10, and pointers wrap at least twice.
- Simultaneous push/pop at count=2 -> count_o stays 2 and the head advances by one.
- Flush: with 3 entries and alu_valid_i=1 in the flush cycle -> alu_ready_o=0 that cycle, next cycle count_o=0, wb_valid_o=0, and the flush-cycle result is not stored.
- Reset mid-operation: with 3 entries and wb_ready_i=1, assert rst_i for 1 cycle -> next cycle wb_valid_o=0, count_o=0; no stale entry ever presented.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// Writeback buffer behind the integer ALU: captures each result, branch bit and
// transaction ID into a small in-order FIFO until the writeback port takes it.
module alu_wb_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 64,
  parameter int TRANS_ID_W = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [DATA_W-1:0]        alu_result_i,
  input  logic                     alu_branch_res_i,
  input  logic [TRANS_ID_W-1:0]    alu_trans_id_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [DATA_W-1:0]        wb_result_o,
  output logic                     wb_branch_res_o,
  output logic [TRANS_ID_W-1:0]    wb_trans_id_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic                  branch_res;
    logic [TRANS_ID_W-1:0] trans_id;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the sender holds its payload
  // stable until the transfer. alu_ready_o never looks at wb_ready_i, so a
  // full buffer stays closed for one cycle even when it is being drained.
  assign alu_ready_o = (count < CW'(DEPTH)) & ~flush_i;
  assign wb_valid_o  = (count != '0);
  assign push        = alu_valid_i & alu_ready_o;
  assign pop         = wb_valid_o & wb_ready_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= '{result:     alu_result_i,
                       branch_res: alu_branch_res_i,
                       trans_id:   alu_trans_id_i};
    end
  end

  assign head = mem[rd_ptr];

  // Outputs read as zero while empty so stale storage never leaks out.
  assign wb_result_o     = wb_valid_o ? head.result     : '0;
  assign wb_branch_res_o = wb_valid_o ? head.branch_res : 1'b0;
  assign wb_trans_id_o   = wb_valid_o ? head.trans_id   : '0;
  assign count_o         = count;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer: reset, single push, fill/backpressure,
// wrap-around with a scoreboard queue, flush and reset mid-drain.
module tb_alu_wb_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alu_valid;
  logic        alu_ready;
  logic [63:0] alu_result;
  logic        alu_branch_res;
  logic [2:0]  alu_trans_id;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_result;
  logic        wb_branch_res;
  logic [2:0]  wb_trans_id;
  logic [2:0]  count;

  int vectors;
  int miscompares;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  alu_wb_buffer #(.DEPTH(4), .DATA_W(64), .TRANS_ID_W(3)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .alu_valid_i      (alu_valid),
    .alu_ready_o      (alu_ready),
    .alu_result_i     (alu_result),
    .alu_branch_res_i (alu_branch_res),
    .alu_trans_id_i   (alu_trans_id),
    .wb_valid_o       (wb_valid),
    .wb_ready_i       (wb_ready),
    .wb_result_o      (wb_result),
    .wb_branch_res_o  (wb_branch_res),
    .wb_trans_id_o    (wb_trans_id),
    .count_o          (count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [63:0] r,
                           input logic b, input logic [2:0] id);
    alu_valid      = v;
    alu_result     = r;
    alu_branch_res = b;
    alu_trans_id   = id;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    wb_ready    = 1'b0;
    drive_alu(1'b0, 64'h0, 1'b0, 3'd0);

    // Reset held for two cycles
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_alu_ready", 64'(alu_ready), 64'd1);
    chk("reset_wb_result", wb_result, 64'd0);
    chk("reset_wb_id", 64'(wb_trans_id), 64'd0);

    // Single push, visible one cycle later, then popped
    wb_ready = 1'b1;
    drive_alu(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 3'd3);
    tick();
    drive_alu(1'b0, 64'h0, 1'b0, 3'd0);
    chk("single_wb_valid", 64'(wb_valid), 64'd1);
    chk("single_result", wb_result, 64'hDEAD_BEEF_0000_0001);
    chk("single_branch", 64'(wb_branch_res), 64'd1);
    chk("single_id", 64'(wb_trans_id), 64'd3);
    chk("single_count", 64'(count), 64'd1);
    tick();
    chk("single_drained_count", 64'(count), 64'd0);
    chk("single_drained_valid", 64'(wb_valid), 64'd0);

    // Fill with backpressure
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_alu(1'b1, 64'h100 + 64'(i), i[0], 3'(i));
      tick();
    end
    drive_alu(1'b1, 64'h104, 1'b0, 3'd4);
    chk("full_count", 64'(count), 64'd4);
    chk("full_alu_ready", 64'(alu_ready), 64'd0);
    chk("full_head_id", 64'(wb_trans_id), 64'd0);
    tick();
    chk("held_not_captured_count", 64'(count), 64'd4);
    chk("held_head_stable_id", 64'(wb_trans_id), 64'd0);
    chk("held_head_stable_result", wb_result, 64'h100);

    // Drain: full buffer stays closed during the first pop, then reopens
    wb_ready = 1'b1;
    #1;
    chk("full_pop_cycle_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    chk("after_first_pop_alu_ready", 64'(alu_ready), 64'd1);
    chk("after_first_pop_count", 64'(count), 64'd3);
    chk("order_id1", 64'(wb_trans_id), 64'd1);
    tick();
    drive_alu(1'b0, 64'h0, 1'b0, 3'd0);
    chk("push_pop_count", 64'(count), 64'd3);
    chk("order_id2", 64'(wb_trans_id), 64'd2);
    tick();
    chk("order_id3", 64'(wb_trans_id), 64'd3);
    tick();
    chk("order_id4", 64'(wb_trans_id), 64'd4);
    chk("order_id4_result", wb_result, 64'h104);
    tick();
    chk("drain_empty_valid", 64'(wb_valid), 64'd0);

    // Wrap-around: prefill two, then ten push/pop pairs, then drain
    wb_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      drive_alu(1'b1, 64'(k), 1'b0, 3'(k));
      exp_q.push_back(64'(k));
      tick();
    end
    chk("wrap_prefill_count", 64'(count), 64'd2);
    wb_ready = 1'b1;
    for (int k = 3; k <= 12; k++) begin
      drive_alu(1'b1, 64'(k), 1'b0, 3'(k));
      exp_q.push_back(64'(k));
      exp_v = exp_q.pop_front();
      #1;
      chk("wrap_head", wb_result, exp_v);
      tick();
      chk("wrap_count_held", 64'(count), 64'd2);
    end
    drive_alu(1'b0, 64'h0, 1'b0, 3'd0);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk("wrap_drain_head", wb_result, exp_v);
      tick();
    end
    chk("wrap_empty_valid", 64'(wb_valid), 64'd0);

    // Flush with three entries and a push attempt in the flush cycle
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 64'hA0 + 64'(i), 1'b1, 3'(i));
      tick();
    end
    chk("preflush_count", 64'(count), 64'd3);
    flush = 1'b1;
    drive_alu(1'b1, 64'hFF, 1'b1, 3'd7);
    #1;
    chk("flush_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive_alu(1'b0, 64'h0, 1'b0, 3'd0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_wb_result", wb_result, 64'd0);
    tick();
    chk("flush_push_not_stored", 64'(count), 64'd0);
    drive_alu(1'b1, 64'h55, 1'b0, 3'd5);
    tick();
    drive_alu(1'b0, 64'h0, 1'b0, 3'd0);
    chk("postflush_head", wb_result, 64'h55);
    chk("postflush_id", 64'(wb_trans_id), 64'd5);
    wb_ready = 1'b1;
    tick();
    chk("postflush_empty", 64'(count), 64'd0);

    // Reset mid-drain
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 64'hC0 + 64'(i), 1'b0, 3'(i));
      tick();
    end
    drive_alu(1'b0, 64'h0, 1'b0, 3'd0);
    chk("prereset_count", 64'(count), 64'd3);
    wb_ready = 1'b1;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_wb_valid", 64'(wb_valid), 64'd0);
    chk("midreset_alu_ready", 64'(alu_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midreset_no_stale", 64'(wb_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
